// File: rtl/in_qualifier.sv
// Qualifies an asynchronous data/enable pair: two-flop synchronizers, a debounce FSM
// that emits a one-cycle strobe once the data has been stable, and a saturating restart counter.
module in_qualifier #(
   parameter int unsigned DEBOUNCE_CNT = 4,
   parameter int unsigned GLITCH_W     = 8
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic                RAW_DATA,
   input  logic                RAW_EN,
   output logic                OUT_DATA,
   output logic                OUT_EN,
   output logic [1:0]          STATE,
   output logic [GLITCH_W-1:0] GLITCH_CNT
);

   typedef enum logic [1:0] {
      StIdle    = 2'b00,
      StSettle  = 2'b01,
      StArmed   = 2'b10,
      StIllegal = 2'b11
   } state_e;

   localparam logic [3:0] CntLast = 4'(DEBOUNCE_CNT - 1);

   logic [1:0]          data_sync_q, en_sync_q;
   logic                s_data, s_en;
   state_e              state_q, state_d;
   logic                cand_q, cand_d;
   logic [3:0]          cnt_q, cnt_d;
   logic                out_data_q, out_data_d;
   logic                out_en_q, out_en_d;
   logic [GLITCH_W-1:0] glitch_q, glitch_d;
   logic                glitch_inc;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         data_sync_q <= 2'b00;
         en_sync_q   <= 2'b00;
      end else begin
         data_sync_q <= {data_sync_q[0], RAW_DATA};
         en_sync_q   <= {en_sync_q[0], RAW_EN};
      end
   end

   assign s_data = data_sync_q[1];
   assign s_en   = en_sync_q[1];

   always_comb begin
      state_d    = state_q;
      cand_d     = cand_q;
      cnt_d      = cnt_q;
      out_data_d = out_data_q;
      out_en_d   = 1'b0;
      glitch_inc = 1'b0;
      case (state_q)
         StIdle: begin
            if (s_en) begin
               state_d = StSettle;
               cand_d  = s_data;
               cnt_d   = 4'd0;
            end
         end
         StSettle: begin
            // Losing the enable wins over any data change seen on the same sample.
            if (!s_en) begin
               state_d = StIdle;
            end else if (s_data != cand_q) begin
               cand_d     = s_data;
               cnt_d      = 4'd0;
               glitch_inc = 1'b1;
            end else if (cnt_q != CntLast) begin
               cnt_d = cnt_q + 4'd1;
            end else begin
               state_d    = StArmed;
               out_data_d = cand_q;
               out_en_d   = 1'b1;
            end
         end
         StArmed: begin
            if (!s_en) begin
               state_d = StIdle;
            end else if (s_data != out_data_q) begin
               state_d    = StSettle;
               cand_d     = s_data;
               cnt_d      = 4'd0;
               glitch_inc = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
      glitch_d = (glitch_inc && (glitch_q != '1)) ? glitch_q + 1'b1 : glitch_q;
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q    <= StIdle;
         cand_q     <= 1'b0;
         cnt_q      <= 4'd0;
         out_data_q <= 1'b0;
         out_en_q   <= 1'b0;
         glitch_q   <= '0;
      end else begin
         state_q    <= state_d;
         cand_q     <= cand_d;
         cnt_q      <= cnt_d;
         out_data_q <= out_data_d;
         out_en_q   <= out_en_d;
         glitch_q   <= glitch_d;
      end
   end

   assign OUT_DATA   = out_data_q;
   assign OUT_EN     = out_en_q;
   assign STATE      = state_q;
   assign GLITCH_CNT = glitch_q;

endmodule
